// File: rtl/rx_ltssm_sequencer.sv
// Receive-side LTSSM substate sequencer: Detect -> Polling -> Configuration -> Config.Idle.
// Optional trace outputs (trans_cnt, last_fail) are enabled by defining RX_LTSSM_TRACE_EN.
module rx_ltssm_sequencer #(
    parameter int unsigned DEVICETYPE      = 0,
    parameter int unsigned QUIET_CYCLES    = 16,
    parameter int unsigned POLL_ACTIVE_CNT = 8,
    parameter int unsigned POLL_CFG_CNT    = 8,
    parameter int unsigned CFG_CNT         = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 24000,
    parameter int unsigned TMR_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx_detected,
    input  logic       countup,
    input  logic       resetcounter,
    output logic [3:0] substate,
    output logic       chk_reset_n,
    output logic [4:0] consec_cnt,
    output logic       timeout_err,
    output logic       linkup
`ifdef RX_LTSSM_TRACE_EN
   ,output logic [7:0] trans_cnt,
    output logic [3:0] last_fail
`endif
);

    typedef enum logic [3:0] {
        StDquiet    = 4'd0,
        StDactive   = 4'd1,
        StPactive   = 4'd2,
        StPcfg      = 4'd3,
        StLwstart   = 4'd4,
        StLwaccept  = 4'd5,
        StLnwait    = 4'd6,
        StLnaccept  = 4'd7,
        StCcomplete = 4'd8,
        StCidle     = 4'd9
    } state_e;

    localparam logic [4:0]       PaTarget  = 5'(POLL_ACTIVE_CNT);
    localparam logic [4:0]       PcTarget  = 5'(POLL_CFG_CNT);
    localparam logic [4:0]       CfgTarget = 5'(CFG_CNT);
    localparam logic [TMR_W-1:0] QuietLast = TMR_W'(QUIET_CYCLES - 1);
    localparam logic [TMR_W-1:0] ToLast    = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d, adv_state;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       target;
    logic             cnt_met;
    logic             state_change;
    logic             chk_rst_n_q;
    logic             timeout_q, timeout_d;
    logic             linkup_q;

    // Per-state count target and successor for the count-driven states.
    always_comb begin
        target    = CfgTarget;
        adv_state = StDquiet;
        case (state_q)
            StPactive: begin
                target    = PaTarget;
                adv_state = StPcfg;
            end
            StPcfg: begin
                target    = PcTarget;
                adv_state = StLwstart;
            end
            StLwstart:   adv_state = (DEVICETYPE == 1) ? StLwaccept : StLnwait;
            StLwaccept:  adv_state = StLnwait;
            StLnwait:    adv_state = StLnaccept;
            StLnaccept:  adv_state = StCcomplete;
            StCcomplete: adv_state = StCidle;
            default:     adv_state = StDquiet;
        endcase
    end

    assign cnt_met = (cnt_q >= target);

    // Next-state: enable low beats count target, which beats timeout.
    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        if (!enable) begin
            state_d = StDquiet;
        end else begin
            case (state_q)
                StDquiet: begin
                    if (timer_q == QuietLast) state_d = StDactive;
                end
                StDactive: state_d = rx_detected ? StPactive : StDquiet;
                StCidle:   state_d = StCidle;
                StPactive, StPcfg, StLwstart, StLwaccept, StLnwait, StLnaccept, StCcomplete: begin
                    if (cnt_met) begin
                        state_d = adv_state;
                    end else if (timer_q == ToLast) begin
                        state_d   = StDquiet;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = StDquiet;
            endcase
        end
    end

    // Timer and consecutive-count next values.
    always_comb begin
        state_change = (state_d != state_q);

        timer_d = timer_q;
        if (state_change || (state_q == StDquiet && !enable)) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end

        cnt_d = cnt_q;
        if (state_change || !chk_rst_n_q || !resetcounter) begin
            cnt_d = '0;
        end else if (countup && cnt_q != 5'd31) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StDquiet;
            timer_q     <= '0;
            cnt_q       <= '0;
            chk_rst_n_q <= 1'b0;
            timeout_q   <= 1'b0;
            linkup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            chk_rst_n_q <= !state_change;
            timeout_q   <= timeout_d;
            linkup_q    <= (state_d == StCidle);
        end
    end

    assign substate    = state_q;
    assign chk_reset_n = chk_rst_n_q;
    assign consec_cnt  = cnt_q;
    assign timeout_err = timeout_q;
    assign linkup      = linkup_q;

`ifdef RX_LTSSM_TRACE_EN
    logic [7:0] trans_cnt_q;
    logic [3:0] last_fail_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trans_cnt_q <= '0;
            last_fail_q <= '0;
        end else begin
            if (state_change) trans_cnt_q <= trans_cnt_q + 8'd1;
            if (timeout_d)    last_fail_q <= state_q;
        end
    end

    assign trans_cnt = trans_cnt_q;
    assign last_fail = last_fail_q;
`endif

endmodule

// File: tb/tb_rx_ltssm_sequencer.sv
// Bench for rx_ltssm_sequencer: upstream and downstream instances share stimulus and are
// compared every cycle against a behavioural model; trace ports checked if RX_LTSSM_TRACE_EN.
module tb_rx_ltssm_sequencer;

    localparam int QC = 4;
    localparam int TO = 64;
    localparam int PA = 8;
    localparam int PC = 8;
    localparam int CC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic rx_detected = 1'b0;
    logic countup = 1'b0;
    logic resetcounter = 1'b1;

    // Index 0: downstream (DEVICETYPE 0), index 1: upstream (DEVICETYPE 1).
    logic [3:0] sub0, sub1;
    logic       crn0, crn1;
    logic [4:0] cnt0, cnt1;
    logic       te0, te1, lu0, lu1;
`ifdef RX_LTSSM_TRACE_EN
    logic [7:0] tc0, tc1;
    logic [3:0] lf0, lf1;
`endif

    always #5 clk = ~clk;

    rx_ltssm_sequencer #(
        .DEVICETYPE(0), .QUIET_CYCLES(QC), .POLL_ACTIVE_CNT(PA), .POLL_CFG_CNT(PC),
        .CFG_CNT(CC), .TIMEOUT_CYCLES(TO), .TMR_W(16)
    ) u_dut_dn (
        .clk(clk), .reset(reset), .enable(enable), .rx_detected(rx_detected),
        .countup(countup), .resetcounter(resetcounter), .substate(sub0),
        .chk_reset_n(crn0), .consec_cnt(cnt0), .timeout_err(te0), .linkup(lu0)
`ifdef RX_LTSSM_TRACE_EN
       ,.trans_cnt(tc0), .last_fail(lf0)
`endif
    );

    rx_ltssm_sequencer #(
        .DEVICETYPE(1), .QUIET_CYCLES(QC), .POLL_ACTIVE_CNT(PA), .POLL_CFG_CNT(PC),
        .CFG_CNT(CC), .TIMEOUT_CYCLES(TO), .TMR_W(16)
    ) u_dut_up (
        .clk(clk), .reset(reset), .enable(enable), .rx_detected(rx_detected),
        .countup(countup), .resetcounter(resetcounter), .substate(sub1),
        .chk_reset_n(crn1), .consec_cnt(cnt1), .timeout_err(te1), .linkup(lu1)
`ifdef RX_LTSSM_TRACE_EN
       ,.trans_cnt(tc1), .last_fail(lf1)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_sub[2];
    int m_cnt[2];
    int m_tmr[2];
    bit m_crn[2];
    bit m_te[2];
    bit m_lu[2];
    int m_tc[2];
    int m_lf[2];

    int order_dn[7] = '{2, 3, 4, 6, 7, 8, 9};
    int order_up[8] = '{2, 3, 4, 5, 6, 7, 8, 9};

    function automatic int next_sub(int d, int s);
        if (d == 0) begin
            for (int i = 0; i < 6; i++) if (order_dn[i] == s) return order_dn[i+1];
        end else begin
            for (int i = 0; i < 7; i++) if (order_up[i] == s) return order_up[i+1];
        end
        return 0;
    endfunction

    function automatic int target(int s);
        if (s == 2) return PA;
        if (s == 3) return PC;
        return CC;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sub[d] = 0; m_cnt[d] = 0; m_tmr[d] = 0; m_crn[d] = 0;
            m_te[d] = 0; m_lu[d] = 0; m_tc[d] = 0; m_lf[d] = 0;
        end
    endfunction

    function automatic void model_step(int d);
        int s = m_sub[d];
        int nxt = s;
        bit terr = 0;
        bit changed;
        if (!enable) nxt = 0;
        else if (s == 0) begin
            if (m_tmr[d] == QC - 1) nxt = 1;
        end else if (s == 1) nxt = rx_detected ? 2 : 0;
        else if (s >= 2 && s <= 8) begin
            if (m_cnt[d] >= target(s)) nxt = next_sub(d, s);
            else if (m_tmr[d] == TO - 1) begin
                nxt = 0;
                terr = 1;
            end
        end
        changed = (nxt != s);
        if (changed || !m_crn[d] || !resetcounter) m_cnt[d] = 0;
        else if (countup && m_cnt[d] < 31) m_cnt[d] = m_cnt[d] + 1;
        if (changed || (s == 0 && !enable)) m_tmr[d] = 0;
        else if (m_tmr[d] < 65535) m_tmr[d] = m_tmr[d] + 1;
        m_crn[d] = !changed;
        m_lu[d] = (nxt == 9);
        m_te[d] = terr;
        if (changed) m_tc[d] = (m_tc[d] + 1) % 256;
        if (terr) m_lf[d] = s;
        m_sub[d] = nxt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("sub_dn", 32'(sub0), m_sub[0]);
        chk("sub_up", 32'(sub1), m_sub[1]);
        chk("chk_reset_n_dn", 32'(crn0), 32'(m_crn[0]));
        chk("chk_reset_n_up", 32'(crn1), 32'(m_crn[1]));
        chk("consec_cnt_dn", 32'(cnt0), m_cnt[0]);
        chk("consec_cnt_up", 32'(cnt1), m_cnt[1]);
        chk("timeout_err_dn", 32'(te0), 32'(m_te[0]));
        chk("timeout_err_up", 32'(te1), 32'(m_te[1]));
        chk("linkup_dn", 32'(lu0), 32'(m_lu[0]));
        chk("linkup_up", 32'(lu1), 32'(m_lu[1]));
`ifdef RX_LTSSM_TRACE_EN
        chk("trans_cnt_dn", 32'(tc0), m_tc[0]);
        chk("trans_cnt_up", 32'(tc1), m_tc[1]);
        chk("last_fail_dn", 32'(lf0), m_lf[0]);
        chk("last_fail_up", 32'(lf1), m_lf[1]);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_dn, p_up, seen5, te_cnt, strobe_gap;
`ifdef RX_LTSSM_TRACE_EN
        int tc_before;
`endif
        // Reset state.
        model_reset();
        #3;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b1;
        rx_detected = 1'b1;
        resetcounter = 1'b1;

        // Happy path with randomly gapped strobes.
        p_dn = 0; p_up = 0; seen5 = 0;
        for (int i = 0; i < 600 && !(m_lu[0] && m_lu[1]); i++) begin
            countup = ($urandom_range(3) != 0);
            step();
            if (crn0 === 1'b0) p_dn++;
            if (crn1 === 1'b0) p_up++;
            if (sub0 === 4'd5) seen5 = 1;
        end
        chk("happy_linkup_up", 32'(lu1), 1);
        chk("happy_linkup_dn", 32'(lu0), 1);
        chk("happy_pulses_up", p_up, 9);
        chk("happy_pulses_dn", p_dn, 8);
        chk("dn_skips_lwaccept", seen5, 0);
        repeat (5) begin
            countup = $urandom_range(1);
            step();
        end
        chk("cidle_hold", 32'(sub1), 9);

        // Abort from LNWAIT.
        enable = 1'b0;
        step();
        enable = 1'b1;
        countup = 1'b1;
        for (int i = 0; i < 200 && m_sub[1] != 6; i++) step();
        chk("reach_lnwait", 32'(sub1), 6);
        enable = 1'b0;
        step();
        chk("abort_sub", 32'(sub1), 0);
        chk("abort_no_terr", 32'(te1), 0);

        // Timeout after 7 strobes in PACTIVE.
        enable = 1'b1;
        te_cnt = 0;
        for (int i = 0; i < 400 && !m_te[1]; i++) begin
            countup = (m_sub[1] == 2 && m_cnt[1] < 7 && m_crn[1]);
            step();
            if (te1 === 1'b1) te_cnt++;
        end
        countup = 1'b0;
        chk("timeout_err", 32'(te1), 1);
        chk("timeout_sub", 32'(sub1), 0);
        chk("timeout_cnt", 32'(cnt1), 0);
        step();
        if (te1 === 1'b1) te_cnt++;
        chk("timeout_pulse_len", te_cnt, 1);

        // Broken run: 5 strobes, one clear, 8 strobes.
        enable = 1'b0;
        step();
        enable = 1'b1;
        countup = 1'b0;
        for (int i = 0; i < 50 && !(m_sub[1] == 2 && m_crn[1]); i++) step();
        repeat (5) begin
            countup = 1'b1;
            step();
        end
        chk("broken_5", 32'(cnt1), 5);
        countup = 1'b0;
        resetcounter = 1'b0;
        step();
        chk("broken_clear", 32'(cnt1), 0);
        resetcounter = 1'b1;
        repeat (8) begin
            countup = 1'b1;
            step();
        end
        countup = 1'b0;
        chk("broken_8", 32'(cnt1), 8);
        chk("broken_still_pactive", 32'(sub1), 2);
        step();
        chk("broken_pcfg", 32'(sub1), 3);

        // Count target coincides with timeout.
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int i = 0; i < 200 && !(m_sub[1] == 2 && m_tmr[1] == TO - 1); i++) begin
            strobe_gap = m_tmr[1];
            countup = (m_sub[1] == 2 && strobe_gap >= TO - 1 - PA && strobe_gap <= TO - 2);
            step();
        end
        countup = 1'b0;
        chk("boundary_cnt", 32'(cnt1), PA);
`ifdef RX_LTSSM_TRACE_EN
        tc_before = int'(tc1);
`endif
        step();
        chk("boundary_adv", 32'(sub1), 3);
        chk("boundary_no_terr", 32'(te1), 0);
`ifdef RX_LTSSM_TRACE_EN
        chk("boundary_trans", 32'(tc1), (tc_before + 1) % 256);
`endif

        // Random soak at several strobe densities.
        foreach (order_up[k]) begin
            int pct;
            if (k > 3) break;
            pct = (k == 0) ? 10 : (k == 1) ? 50 : (k == 2) ? 90 : 0;
            repeat (500) begin
                enable = ($urandom_range(31) != 0);
                rx_detected = ($urandom_range(3) != 0);
                countup = ($urandom_range(99) < pct);
                resetcounter = ($urandom_range(15) != 0);
                step();
            end
        end

        // Asynchronous reset mid-CCOMPLETE.
        enable = 1'b1;
        rx_detected = 1'b1;
        resetcounter = 1'b1;
        countup = 1'b1;
        for (int i = 0; i < 300 && m_sub[1] != 8; i++) step();
        chk("reach_ccomplete", 32'(sub1), 8);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        countup = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
